muxcont_rr: RTL
===============

# muxcont_rr

Parametrised output-port allocator for the on-chip packet switch. Each output port of the crossbar instantiates one. It collects per-input requests whose destination field matches its own PORTID and picks one input with a round-robin pointer. It holds that grant for a whole packet until the tail flit is transferred, and releases it early on owner abort or stall timeout. Its registered one-hot `sel` drives the output-port data mux; its combinational `grt` is the per-input flit-accept strobe.

## Interface
- `NPORT`, 6: number of input channels (2..16).
- `PORTW`, 3: width of each destination field.
- `PORTID`, 0: output-port number this instance serves.
- `TIMEOUT`, 64: stall cycles in HOLD before forced release; 0 disables the timeout.
- `IDW`, derived: ceil(log2(NPORT)).

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` upstream).
- `dst`  in  NPORT*PORTW  destination fields; channel i is bits [i*PORTW +: PORTW].
- `req`  in  NPORT  per-input flit-valid request.
- `tail`  in  NPORT  per-input "current flit is last of packet".
- `ready`  in  1  downstream can accept a flit this cycle (credit available).
- `sel`  out  NPORT  registered one-hot owner; all-zero when idle.
- `sel_id`  out  IDW  registered binary index of owner; 0 when idle.
- `grt`  out  NPORT  combinational transfer strobe: `sel & match & ready`.
- `busy`  out  1  registered; 1 in HOLD.
- `timeout`  out  1  registered one-cycle pulse on forced release.

## Operation
- `match[i] = req[i] & (dst[i] == PORTID)`. Non-matching requests are invisible to this block.
- States:
  - **IDLE**: `sel` = 0, `busy` = 0.
  - **HOLD**: `sel` = one-hot owner, `busy` = 1.
- **IDLE -> HOLD**, when any `match` bit is set (independent of `ready`):
  - Winner is the first set `match` bit scanning upward from `ptr`, wrapping NPORT-1 -> 0.
  - Next edge loads `sel`, `sel_id`, and `busy` = 1.
  - Stall counter clears.
- **Transfer**, in HOLD: a transfer occurs in a cycle where `grt[owner]` = 1. It clears the stall counter.
- **HOLD -> IDLE**, on the first of the following:
  - (a) transfer with `tail[owner]` = 1;
  - (b) `match[owner]` = 0 (owner abort; no transfer that cycle);
  - (c) stall counter reaches TIMEOUT-1 with no transfer in that cycle (TIMEOUT ≠ 0); `timeout` pulses high for the following cycle.
- On every release, `ptr` <= (owner+1) mod NPORT.
- Stall counter:
  - Increments in HOLD cycles with `match[owner]` = 1 and no transfer.
  - Saturates at TIMEOUT-1.
  - Width is ceil(log2(TIMEOUT+1)).
- Priority among simultaneous conditions: tail transfer > abort > timeout. Exactly one release is taken, with a single `ptr` update.
- `grt` is never asserted for a non-owner. It is never asserted in IDLE or while `ready` = 0.
- A request whose `dst` changes mid-packet is treated as an abort, since its `match` drops.

## Timing
- Reset values: `sel` = 0, `sel_id` = 0, `busy` = 0, `timeout` = 0, `ptr` = 0, stall counter = 0. `grt` = 0 because it follows `sel`.
- Arbitration latency: `match` rises at cycle t in IDLE -> `sel` valid at t+1. The first `grt` is possible at t+1.
- Release: tail transfer at cycle t -> IDLE at t+1 -> next owner's `sel` at t+2. There is one bubble cycle between packets.
- A single-flit packet (tail on the first flit) with `ready` = 1 occupies HOLD for exactly one cycle.
- `rst` low at any time forces all registers to reset values within the same cycle. An in-flight packet is dropped by the allocator; the upstream is expected to be reset too.
- `ptr` wrap: owner NPORT-1 released -> `ptr` = 0.

## Test plan
- **Reset/idle**: `rst` low, then high, with no `req` -> `sel` = 0, `busy` = 0, `grt` = 0 for 10 cycles. Also `req[2]` = 1 with `dst[2]` = PORTID+1 -> still idle.
- **Basic packet**: `req[1]` with a 3-flit packet, `ready` = 1 -> `sel` = 6'b000010 one cycle later; `grt[1]` high for 3 cycles; `busy` drops the cycle after the tail.
- **Round-robin fairness**: `req[0]`, `req[3]`, `req[5]` all continuously matching with single-flit packets -> owners 0, 3, 5, 0, 3, ... with one idle cycle between each.
- **Backpressure**: owner 4, `ready` toggles 1,0,0,1 within the packet -> `grt[4]` only in `ready` cycles; `sel` is held throughout; no release until the tail transfer.
- **Abort and wrap**: owner 5 drops `req[5]` mid-packet -> IDLE next cycle, `ptr` = 0. With `req[0]` and `req[5]` both pending, 0 wins next.
- **Timeout**: TIMEOUT = 4, owner 2 with `ready` = 0 throughout -> release after 4 HOLD cycles; `timeout` high for one cycle; `ptr` = 3.

Source files
------------

// File: rtl/muxcont_rr.sv
// Output-port allocator: round-robin pick among inputs addressed to PORTID,
// grant held for a whole packet, released on tail, owner abort or stall timeout.
module muxcont_rr #(
  parameter int unsigned NPORT   = 6,
  parameter int unsigned PORTW   = 3,
  parameter int unsigned PORTID  = 0,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDW    = $clog2(NPORT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*PORTW-1:0] dst,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT-1:0]       tail,
  input  logic                   ready,
  output logic [NPORT-1:0]       sel,
  output logic [IDW-1:0]         sel_id,
  output logic [NPORT-1:0]       grt,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [NPORT-1:0] sel_q, sel_d;
  logic [IDW-1:0]   sel_id_q, sel_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NPORT-1:0] match;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  int unsigned      idx;
  logic             own_match;
  logic             xfer;
  logic             to_hit;
  logic             rel;
  logic [IDW-1:0]   next_ptr;

  // Requests addressed to this output port
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      match[i] = req[i] & (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
    end
  end

  // First matching input at or above ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      cand = IDW'(idx);
      if (!win_found && match[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign own_match = match[sel_id_q];
  assign xfer      = (state_q == ST_HOLD) && own_match && ready;
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == CNT_MAX) && !xfer;
  assign next_ptr  = (sel_id_q == IDW'(NPORT - 1)) ? '0 : sel_id_q + IDW'(1);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_id_d  = sel_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rel       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_HOLD;
          sel_d    = NPORT'(1) << win_id;
          sel_id_d = win_id;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_HOLD: begin
        // Release priority: tail transfer, then abort, then timeout
        if (xfer && tail[sel_id_q]) begin
          rel = 1'b1;
        end else if (!own_match) begin
          rel = 1'b1;
        end else if (to_hit) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else if (xfer) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (rel) begin
          state_d  = ST_IDLE;
          sel_d    = '0;
          sel_id_d = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          ptr_d    = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      sel_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_id_q  <= sel_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign sel_id  = sel_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign grt     = sel_q & match & {NPORT{ready}};

endmodule
